// File: rtl/afe_lbnl_multi_ch_ctrl.sv
// Control block for N_CH LBNL-style analog front-end channels.
// It holds each channel's configuration, synchronises the discriminator
// outputs, measures time-over-threshold, and queues finished hits into a FIFO
// through a round-robin arbiter.
module afe_lbnl_multi_ch_ctrl #(
  parameter int N_CH        = 4,
  parameter int TRIM_W      = 4,
  parameter int TOT_W       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       CLK,
  input  logic                       RST_B,
  input  logic                       cfg_we,
  input  logic [$clog2(N_CH)-1:0]    cfg_addr,
  input  logic [2*TRIM_W+2:0]        cfg_wdata,
  output logic [N_CH-1:0]            S0,
  output logic [N_CH-1:0]            S1,
  output logic [N_CH*TRIM_W-1:0]     DTH1,
  output logic [N_CH*TRIM_W-1:0]     DTH2,
  input  logic [N_CH-1:0]            outdis,
  output logic                       hit_valid,
  input  logic                       hit_ready,
  output logic [$clog2(N_CH)-1:0]    hit_ch,
  output logic [TOT_W-1:0]           hit_tot,
  output logic                       hit_sat,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(N_CH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + TOT_W + 1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_PEND
  } ch_state_t;

  logic [N_CH-1:0]        mask;
  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [N_CH-1:0]        sync_out;
  logic [N_CH-1:0]        hit;
  logic [N_CH-1:0]        hit_prev;

  ch_state_t              state      [N_CH];
  ch_state_t              state_next [N_CH];
  logic [TOT_W-1:0]       tot        [N_CH];
  logic [TOT_W-1:0]       tot_next   [N_CH];
  logic [N_CH-1:0]        sat;
  logic [N_CH-1:0]        sat_next;
  logic [N_CH-1:0]        drop;
  logic [N_CH-1:0]        pend;
  logic [8:0]             drop_sum;

  logic [AW-1:0]          rr_ptr;
  logic                   grant_valid;
  logic [AW-1:0]          grant_ch;
  logic [AW-1:0]          grant_idx;
  logic [N_CH-1:0]        grant_vec;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          push_data;
  logic [EW-1:0]          head_q;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          ram_cnt;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  logic                   load_head;

  // Configuration registers; an address beyond N_CH matches no channel and is ignored.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      S0   <= '0;
      S1   <= '0;
      DTH1 <= '0;
      DTH2 <= '0;
      mask <= '1;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_we && (cfg_addr == AW'(c))) begin
          DTH1[c*TRIM_W +: TRIM_W] <= cfg_wdata[TRIM_W-1:0];
          DTH2[c*TRIM_W +: TRIM_W] <= cfg_wdata[2*TRIM_W-1:TRIM_W];
          S0[c]                    <= cfg_wdata[2*TRIM_W];
          S1[c]                    <= cfg_wdata[2*TRIM_W+1];
          mask[c]                  <= cfg_wdata[2*TRIM_W+2];
        end
      end
    end
  end

  // Discriminator synchronisers, preset to the inactive (high) level.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int c = 0; c < N_CH; c++) sync_q[c] <= '1;
    end else begin
      for (int c = 0; c < N_CH; c++) sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], outdis[c]};
    end
  end

  // Qualified hit: the discriminator is active-low and a masked channel never hits.
  always_comb begin
    for (int c = 0; c < N_CH; c++) sync_out[c] = sync_q[c][SYNC_STAGES-1];
    hit = ~sync_out & ~mask;
  end

  // Pending flags; these form the arbiter request vector.
  always_comb begin
    for (int c = 0; c < N_CH; c++) pend[c] = (state[c] == ST_PEND);
  end

  // Round-robin search, starting at the pointer; no grant while the FIFO is full.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    grant_idx   = '0;
    grant_vec   = '0;
    if (!fifo_full) begin
      for (int i = 0; i < N_CH; i++) begin
        grant_idx = AW'((int'(rr_ptr) + i) % N_CH);
        if (!grant_valid && pend[grant_idx]) begin
          grant_valid = 1'b1;
          grant_ch    = grant_idx;
        end
      end
    end
    if (grant_valid) grant_vec[grant_ch] = 1'b1;
  end

  // Per-channel ToT FSM. A count starts only on a rising hit, so a hit still high after the grant is ignored.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_next[c] = state[c];
      tot_next[c]   = tot[c];
      sat_next[c]   = sat[c];
      drop[c]       = 1'b0;
      case (state[c])
        ST_IDLE: begin
          if (hit[c] && !hit_prev[c]) begin
            state_next[c] = ST_COUNT;
            tot_next[c]   = TOT_W'(1);
            sat_next[c]   = 1'b0;
          end
        end
        ST_COUNT: begin
          if (mask[c]) begin
            state_next[c] = ST_IDLE;
          end else if (hit[c]) begin
            if (tot[c] == TOT_MAX) sat_next[c] = 1'b1;
            else                   tot_next[c] = tot[c] + 1'b1;
          end else begin
            state_next[c] = ST_PEND;
          end
        end
        ST_PEND: begin
          drop[c] = hit[c] && !hit_prev[c];
          if (grant_vec[c]) state_next[c] = ST_IDLE;
        end
        default: state_next[c] = ST_IDLE;
      endcase
    end
  end

  // Channel state, ToT and previous-hit registers.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int c = 0; c < N_CH; c++) begin
        state[c] <= ST_IDLE;
        tot[c]   <= '0;
      end
      sat      <= '0;
      hit_prev <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state[c] <= state_next[c];
        tot[c]   <= tot_next[c];
      end
      sat      <= sat_next;
      hit_prev <= hit;
    end
  end

  // Sum of this cycle's drops; several channels can drop in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int c = 0; c < N_CH; c++) drop_sum = drop_sum + 9'(drop[c]);
  end

  // Saturating drop counter and round-robin pointer.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      drop_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      if (grant_valid) rr_ptr <= (int'(grant_ch) == N_CH - 1) ? '0 : grant_ch + 1'b1;
    end
  end

  // FIFO control. Fullness counts the head register, and a grant sees the pre-pop flag.
  always_comb begin
    fifo_full = (count == CW'(FIFO_DEPTH));
    push      = grant_valid;
    pop       = hit_valid && hit_ready;
    load_head = (!hit_valid || pop) && (ram_cnt != '0);
    push_data = {grant_ch, tot[grant_ch], sat[grant_ch]};
  end

  // FIFO storage array. Reset only clears the pointers, which discards queued entries.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and the registered head entry.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ram_cnt   <= '0;
      head_q    <= '0;
      hit_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (push && !load_head)      ram_cnt <= ram_cnt + 1'b1;
      else if (!push && load_head) ram_cnt <= ram_cnt - 1'b1;
      if (load_head) begin
        head_q    <= mem[rd_ptr];
        hit_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (pop) begin
        hit_valid <= 1'b0;
      end
    end
  end

  assign {hit_ch, hit_tot, hit_sat} = head_q;

endmodule

// File: tb/tb_afe_lbnl_multi_ch_ctrl.sv
// Directed testbench for afe_lbnl_multi_ch_ctrl with hand-computed expectations.
module tb_afe_lbnl_multi_ch_ctrl;

  logic        CLK;
  logic        RST_B;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [10:0] cfg_wdata;
  logic [3:0]  S0;
  logic [3:0]  S1;
  logic [15:0] DTH1;
  logic [15:0] DTH2;
  logic [3:0]  outdis;
  logic        hit_valid;
  logic        hit_ready;
  logic [1:0]  hit_ch;
  logic [3:0]  hit_tot;
  logic        hit_sat;
  logic [7:0]  drop_cnt;

  int checks;
  int errors;
  int drainCh  [9];
  int drainTot [9];

  afe_lbnl_multi_ch_ctrl #(
    .N_CH(4), .TRIM_W(4), .TOT_W(4), .FIFO_DEPTH(8), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RST_B(RST_B), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .S0(S0), .S1(S1), .DTH1(DTH1), .DTH2(DTH2), .outdis(outdis),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ch(hit_ch), .hit_tot(hit_tot),
    .hit_sat(hit_sat), .drop_cnt(drop_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Upper bound on run time so the bench never hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when actual differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Holds the selected discriminators low for len cycles; called on a falling clock edge.
  task automatic applyStimulus(input logic [3:0] chans, input int len);
    outdis = outdis & ~chans;
    repeat (len) @(negedge CLK);
    outdis = outdis | chans;
  endtask

  // Writes one channel's configuration word.
  task automatic writeConfig(input int addr, input logic [10:0] data);
    cfg_addr  = 2'(addr);
    cfg_wdata = data;
    cfg_we    = 1'b1;
    @(negedge CLK);
    cfg_we    = 1'b0;
  endtask

  // Waits a bounded number of cycles for a FIFO head to appear.
  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!hit_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(tag, 32'(hit_valid), 1);
  endtask

  // Checks the head entry, then pops it with a one-cycle ready pulse.
  task automatic popExpect(input string tag, input int ch, input int tot, input int sat);
    waitValid({tag, "_valid"});
    checkOutput({tag, "_ch"}, 32'(hit_ch), ch);
    checkOutput({tag, "_tot"}, 32'(hit_tot), tot);
    checkOutput({tag, "_sat"}, 32'(hit_sat), sat);
    hit_ready = 1'b1;
    @(negedge CLK);
    hit_ready = 1'b0;
  endtask

  // Drives a simultaneous pulse on all channels and expects four back-to-back entries.
  task automatic burstExpect(input string tag, input int first, input int len);
    applyStimulus(4'b1111, len);
    hit_ready = 1'b1;
    waitValid({tag, "_valid"});
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_ch"}, 32'(hit_ch), (first + i) % 4);
      checkOutput({tag, "_tot"}, 32'(hit_tot), len);
      @(negedge CLK);
    end
    checkOutput({tag, "_empty"}, 32'(hit_valid), 0);
    hit_ready = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    checks    = 0;
    errors    = 0;
    drainCh   = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    drainTot  = '{3, 3, 3, 3, 4, 4, 4, 4, 6};
    RST_B     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    outdis    = 4'b1111;
    hit_ready = 1'b0;

    repeat (2) @(negedge CLK);
    checkOutput("rst_s0", 32'(S0), 0);
    checkOutput("rst_s1", 32'(S1), 0);
    checkOutput("rst_dth1", 32'(DTH1), 0);
    checkOutput("rst_dth2", 32'(DTH2), 0);
    checkOutput("rst_valid", 32'(hit_valid), 0);
    checkOutput("rst_drop", 32'(drop_cnt), 0);
    RST_B = 1'b1;
    @(negedge CLK);

    $display("[TB] configuration write");
    writeConfig(2, {1'b0, 1'b1, 1'b0, 4'hA, 4'h5});
    checkOutput("cfg_s0", 32'(S0), 0);
    checkOutput("cfg_s1", 32'(S1), 32'h4);
    checkOutput("cfg_dth2", 32'(DTH2), 32'h0A00);
    checkOutput("cfg_dth1", 32'(DTH1), 32'h0500);
    writeConfig(0, 11'h000);
    checkOutput("cfg_keep_s1", 32'(S1), 32'h4);
    checkOutput("cfg_keep_dth1", 32'(DTH1), 32'h0500);

    $display("[TB] single hit with latency");
    applyStimulus(4'b0001, 5);
    repeat (4) @(negedge CLK);
    checkOutput("lat_early", 32'(hit_valid), 0);
    @(negedge CLK);
    checkOutput("lat_on_time", 32'(hit_valid), 1);
    popExpect("single", 0, 5, 0);
    checkOutput("single_empty", 32'(hit_valid), 0);

    $display("[TB] saturating ToT");
    writeConfig(1, 11'h000);
    applyStimulus(4'b0010, 40);
    popExpect("sat", 1, 15, 1);

    $display("[TB] round-robin bursts");
    writeConfig(3, 11'h000);
    burstExpect("burst_a", 2, 3);
    applyStimulus(4'b1000, 2);
    popExpect("solo3", 3, 2, 0);
    burstExpect("burst_b", 0, 3);
    burstExpect("burst_c", 0, 3);

    $display("[TB] FIFO full, PEND re-hit and drain");
    applyStimulus(4'b1111, 3);
    repeat (10) @(negedge CLK);
    applyStimulus(4'b1111, 4);
    repeat (10) @(negedge CLK);
    applyStimulus(4'b0001, 6);
    repeat (5) @(negedge CLK);
    checkOutput("full_head_ch", 32'(hit_ch), 0);
    checkOutput("full_head_tot", 32'(hit_tot), 3);
    checkOutput("drop_before", 32'(drop_cnt), 0);
    applyStimulus(4'b0001, 2);
    repeat (5) @(negedge CLK);
    checkOutput("drop_after", 32'(drop_cnt), 1);
    checkOutput("hold_head_ch", 32'(hit_ch), 0);
    checkOutput("hold_head_tot", 32'(hit_tot), 3);
    hit_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      waitValid("drain_valid");
      checkOutput("drain_ch", 32'(hit_ch), drainCh[i]);
      checkOutput("drain_tot", 32'(hit_tot), drainTot[i]);
      @(negedge CLK);
    end
    hit_ready = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("drain_empty", 32'(hit_valid), 0);
    checkOutput("drain_drop", 32'(drop_cnt), 1);

    $display("[TB] reset mid-operation");
    applyStimulus(4'b0111, 2);
    repeat (12) @(negedge CLK);
    checkOutput("pre_rst_valid", 32'(hit_valid), 1);
    outdis[3] = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RST_B = 1'b0;
    #1 checkOutput("rst_async_valid", 32'(hit_valid), 0);
    checkOutput("rst_async_drop", 32'(drop_cnt), 0);
    @(negedge CLK);
    outdis = 4'b0000;
    @(negedge CLK);
    RST_B = 1'b1;
    repeat (15) @(negedge CLK);
    checkOutput("post_rst_masked", 32'(hit_valid), 0);
    checkOutput("post_rst_s1", 32'(S1), 0);
    checkOutput("post_rst_dth2", 32'(DTH2), 0);
    checkOutput("post_rst_drop", 32'(drop_cnt), 0);
    outdis = 4'b1111;
    repeat (4) @(negedge CLK);
    writeConfig(0, 11'h000);
    applyStimulus(4'b0001, 4);
    popExpect("post_rst_hit", 0, 4, 0);
    checkOutput("post_rst_empty", 32'(hit_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
